// File: rtl/synch_ctrl.sv
// Receiver synchronizer sequencer: IDLE -> COARSE -> FINE -> PASS -> DONE, all outputs registered (1-cycle latency).
// Optional lock timeout built only when SYNCH_CTRL_TIMEOUT_EN is defined; downstream backpressure via out_ack.
module synch_ctrl #(
    parameter int FRAME_LEN = 240,
    parameter int TMO_LEN   = 4096
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       CYC_I,
    input  logic       STB_I,
    input  logic       coarse_det,
    input  logic       fine_det,
    input  logic       out_ack,
    output logic       nfrm_rst,
    output logic       coarse_ena,
    output logic       fine_ena,
    output logic       pass_ena,
    output logic [9:0] samp_cnt,
    output logic       frame_done,
    output logic       timeout,
    output logic [2:0] state
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        COARSE = 3'd1,
        FINE   = 3'd2,
        PASS   = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [9:0] SAMP_LAST = 10'(FRAME_LEN - 1);

    state_t     state_q, state_d;
    logic       cyc_prev, cyc_low_seen, cyc_rise;
    logic [9:0] samp_d;
    logic       nfrm_d, tmo_hit, tmo_clr, tmo_take;

    // A frame may only start after CYC_I has been seen low since reset.
    assign cyc_rise = CYC_I & ~cyc_prev & cyc_low_seen;

    always_comb begin
        state_d  = state_q;
        samp_d   = samp_cnt;
        nfrm_d   = 1'b0;
        tmo_clr  = 1'b0;
        tmo_take = 1'b0;
        case (state_q)
            IDLE: begin
                if (cyc_rise) begin
                    state_d = COARSE;
                    nfrm_d  = 1'b1;
                    tmo_clr = 1'b1;
                end
            end
            COARSE, FINE: begin
                if (!CYC_I) begin
                    state_d = IDLE;
                    samp_d  = '0;
                end else if (state_q == COARSE && coarse_det) begin
                    state_d = FINE;
                    tmo_clr = 1'b1;
                end else if (state_q == FINE && fine_det) begin
                    state_d = PASS;
                    samp_d  = '0;
                end else if (tmo_hit) begin
                    state_d  = COARSE;
                    nfrm_d   = 1'b1;
                    tmo_clr  = 1'b1;
                    tmo_take = 1'b1;
                end
            end
            PASS: begin
                if (!CYC_I) begin
                    state_d = IDLE;
                    samp_d  = '0;
                end else if (out_ack) begin
                    if (samp_cnt == SAMP_LAST) begin
                        state_d = DONE;
                        samp_d  = '0;
                    end else begin
                        samp_d = samp_cnt + 10'd1;
                    end
                end
            end
            DONE: begin
                tmo_clr = 1'b1;
                if (CYC_I) begin
                    state_d = COARSE;
                    nfrm_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q      <= IDLE;
            cyc_prev     <= 1'b0;
            cyc_low_seen <= 1'b0;
            samp_cnt     <= '0;
            nfrm_rst     <= 1'b0;
            coarse_ena   <= 1'b0;
            fine_ena     <= 1'b0;
            pass_ena     <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_prev   <= CYC_I;
            if (!CYC_I) cyc_low_seen <= 1'b1;
            samp_cnt   <= samp_d;
            nfrm_rst   <= nfrm_d;
            coarse_ena <= (state_d == COARSE);
            fine_ena   <= (state_d == FINE);
            pass_ena   <= (state_d == PASS);
            frame_done <= (state_d == DONE);
        end
    end

    assign state = state_q;

`ifdef SYNCH_CTRL_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TMO_LEN - 1);

    logic [15:0] tmo_cnt;
    logic        stb_acc;

    assign stb_acc = STB_I & CYC_I & ((state_q == COARSE) | (state_q == FINE));
    // Fires on the accepted sample that brings the count to TMO_LEN.
    assign tmo_hit = stb_acc & (tmo_cnt >= TMO_LAST);

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            tmo_cnt <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= tmo_take;
            if (tmo_clr)
                tmo_cnt <= '0;
            else if (stb_acc && tmo_cnt != 16'hFFFF)
                tmo_cnt <= tmo_cnt + 16'd1;
        end
    end
`else
    logic unused_tmo;

    assign tmo_hit    = 1'b0;
    assign timeout    = 1'b0;
    assign unused_tmo = ^{STB_I, tmo_clr, tmo_take, (TMO_LEN == 0)};
`endif

endmodule

// File: tb/tb_synch_ctrl.sv
// Randomized + directed bench for synch_ctrl against a cycle-level behavioural model.
module tb_synch_ctrl;
    localparam int FRAME_LEN = 240;
    localparam int TMO_LEN   = 16;
`ifdef SYNCH_CTRL_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic       CLK_I = 1'b0;
    logic       RST_I = 1'b1;
    logic       CYC_I = 1'b0;
    logic       STB_I = 1'b0;
    logic       coarse_det = 1'b0;
    logic       fine_det = 1'b0;
    logic       out_ack = 1'b0;
    logic       nfrm_rst, coarse_ena, fine_ena, pass_ena, frame_done, timeout;
    logic [9:0] samp_cnt;
    logic [2:0] state;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: frame phase 0..4, counters as plain ints.
    int m_state, m_samp, m_tmo;
    bit m_prev, m_low_seen, m_nfrm, m_tout;

    synch_ctrl #(.FRAME_LEN(FRAME_LEN), .TMO_LEN(TMO_LEN)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .CYC_I(CYC_I), .STB_I(STB_I),
        .coarse_det(coarse_det), .fine_det(fine_det), .out_ack(out_ack),
        .nfrm_rst(nfrm_rst), .coarse_ena(coarse_ena), .fine_ena(fine_ena),
        .pass_ena(pass_ena), .samp_cnt(samp_cnt), .frame_done(frame_done),
        .timeout(timeout), .state(state)
    );

    always #5 CLK_I = ~CLK_I;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_samp = 0; m_tmo = 0;
        m_prev = 1'b0; m_low_seen = 1'b0; m_nfrm = 1'b0; m_tout = 1'b0;
    endtask

    task automatic model_tick();
        int  ns;
        bit  rise;
        if (!RST_I) begin
            model_reset();
            return;
        end
        ns     = m_state;
        m_nfrm = 1'b0;
        m_tout = 1'b0;
        rise   = CYC_I && !m_prev && m_low_seen;
        if (m_state == 0) begin
            if (rise) begin ns = 1; m_nfrm = 1'b1; m_tmo = 0; end
        end else if (m_state == 1 || m_state == 2) begin
            if (!CYC_I) begin
                ns = 0; m_samp = 0;
            end else if (m_state == 1 && coarse_det) begin
                ns = 2; m_tmo = 0;
            end else if (m_state == 2 && fine_det) begin
                ns = 3; m_samp = 0;
            end else if (TMO_ON && STB_I) begin
                m_tmo++;
                if (m_tmo >= TMO_LEN) begin
                    ns = 1; m_tmo = 0; m_nfrm = 1'b1; m_tout = 1'b1;
                end
            end
        end else if (m_state == 3) begin
            if (!CYC_I) begin
                ns = 0; m_samp = 0;
            end else if (out_ack) begin
                if (m_samp == FRAME_LEN - 1) begin m_samp = 0; ns = 4; end
                else m_samp++;
            end
        end else begin
            ns = CYC_I ? 1 : 0; m_nfrm = CYC_I; m_tmo = 0;
        end
        if (!CYC_I) m_low_seen = 1'b1;
        m_prev  = CYC_I;
        m_state = ns;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".state"},      32'(state),      32'(m_state));
        check({tag, ".nfrm_rst"},   32'(nfrm_rst),   32'(m_nfrm));
        check({tag, ".coarse_ena"}, 32'(coarse_ena), 32'(m_state == 1));
        check({tag, ".fine_ena"},   32'(fine_ena),   32'(m_state == 2));
        check({tag, ".pass_ena"},   32'(pass_ena),   32'(m_state == 3));
        check({tag, ".samp_cnt"},   32'(samp_cnt),   32'(m_samp));
        check({tag, ".frame_done"}, 32'(frame_done), 32'(m_state == 4));
        check({tag, ".timeout"},    32'(timeout),    32'(m_tout));
    endtask

    task automatic step(input string tag);
        @(posedge CLK_I);
        model_tick();
        #1;
        compare_all(tag);
    endtask

    task automatic to_pass(input int acks);
        coarse_det = 1'b1; step("to_pass_c"); coarse_det = 1'b0;
        fine_det   = 1'b1; step("to_pass_f"); fine_det   = 1'b0;
        out_ack = 1'b1;
        repeat (acks) step("to_pass_ack");
        out_ack = 1'b0;
    endtask

    initial begin
        int tmo_seen;
        model_reset();
        #1 RST_I = 1'b0;
        #1 compare_all("reset");
        repeat (3) step("reset_hold");
        RST_I = 1'b1;
        repeat (2) step("idle");

        // Frame start on CYC_I rising edge
        CYC_I = 1'b1;
        step("start");
        check("start_state", 32'(state), 32'd1);
        check("start_nfrm", 32'(nfrm_rst), 32'd1);
        check("start_cena", 32'(coarse_ena), 32'd1);
        step("start_next");
        check("start_nfrm_1cyc", 32'(nfrm_rst), 32'd0);

        // Full frame: coarse, fine 10 cycles later, 240 acks
        coarse_det = 1'b1; step("frm_coarse"); coarse_det = 1'b0;
        check("frm_fine_state", 32'(state), 32'd2);
        repeat (9) step("frm_wait");
        fine_det = 1'b1; step("frm_fine"); fine_det = 1'b0;
        check("frm_pass_state", 32'(state), 32'd3);
        out_ack = 1'b1;
        for (int i = 0; i < FRAME_LEN; i++) step("frm_ack");
        out_ack = 1'b0;
        check("frm_done_state", 32'(state), 32'd4);
        check("frm_done_pulse", 32'(frame_done), 32'd1);
        step("frm_rearm");
        check("frm_rearm_state", 32'(state), 32'd1);
        check("frm_rearm_nfrm", 32'(nfrm_rst), 32'd1);

        // Abort beats coarse_det; fine_det ignored in COARSE
        coarse_det = 1'b1; CYC_I = 1'b0;
        step("abort_vs_det"); coarse_det = 1'b0;
        check("abort_vs_det_state", 32'(state), 32'd0);
        step("abort_low");
        CYC_I = 1'b1; step("restart");
        fine_det = 1'b1; step("fine_in_coarse"); fine_det = 1'b0;
        check("fine_in_coarse_state", 32'(state), 32'd1);

        // CYC_I dropped in PASS at samp_cnt=100
        to_pass(100);
        check("pass100_cnt", 32'(samp_cnt), 32'd100);
        CYC_I = 1'b0; step("pass_abort");
        check("pass_abort_state", 32'(state), 32'd0);
        check("pass_abort_cnt", 32'(samp_cnt), 32'd0);
        check("pass_abort_done", 32'(frame_done), 32'd0);
        check("pass_abort_tmo", 32'(timeout), 32'd0);

        // Lock timeout while waiting for coarse_det
        CYC_I = 1'b1; step("tmo_start");
        STB_I = 1'b1;
        tmo_seen = 0;
`ifdef SYNCH_CTRL_TIMEOUT_EN
        for (int i = 0; i < 2 * TMO_LEN; i++) begin
            step("tmo_strobe");
            if (timeout) tmo_seen++;
            if (i == TMO_LEN - 1) begin
                check("tmo_pulse", 32'(timeout), 32'd1);
                check("tmo_nfrm", 32'(nfrm_rst), 32'd1);
                check("tmo_state", 32'(state), 32'd1);
            end
        end
        check("tmo_count", 32'(tmo_seen), 32'd2);
`else
        for (int i = 0; i < 5000; i++) begin
            step("notmo_strobe");
            if (timeout) tmo_seen++;
        end
        check("notmo_count", 32'(tmo_seen), 32'd0);
`endif
        STB_I = 1'b0;

        // Async reset mid-PASS, then release with CYC_I held high
        to_pass(50);
        #2 RST_I = 1'b0;
        #1 model_reset();
        compare_all("async_rst");
        check("async_rst_pass_ena", 32'(pass_ena), 32'd0);
        repeat (2) step("async_rst_hold");
        RST_I = 1'b1;
        repeat (5) step("rst_cyc_high");
        check("rst_cyc_high_state", 32'(state), 32'd0);
        CYC_I = 1'b0; step("rst_cyc_low");

        // Randomized traffic
        for (int i = 0; i < 20000; i++) begin
            RST_I = ($urandom_range(0, 4999) != 0);
            if (!RST_I) begin
                #1 model_reset();
                compare_all("rnd_rst");
            end
            if (CYC_I) CYC_I = ($urandom_range(0, 1499) != 0);
            else       CYC_I = ($urandom_range(0, 4) == 0);
            STB_I      = $urandom_range(0, 1) == 1;
            coarse_det = $urandom_range(0, 19) == 0;
            fine_det   = $urandom_range(0, 19) == 0;
            out_ack    = $urandom_range(0, 3) != 0;
            step("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
